unpackern_tokbit: RTL

Width-reducing serializer: accepts one wide word of `FACTOR*OUT_WIDTH` bits over a valid/ready handshake and emits it as `FACTOR` consecutive `OUT_WIDTH`-bit beats over a second valid/ready handshake. It is the inverse of the team's K-to-N data packer. It sits on the transmit side of a narrow link, ahead of the packer on the far end. With default slice order, a round trip through unpacker then packer reproduces the original word.

---
 rtl/unpacker_pkg.sv | 17 +
 rtl/unpackern_tokbit_mod_counter.sv | 28 ++
 rtl/unpackern_tokbit.sv | 78 +++++++
 3 files changed

// File: rtl/unpacker_pkg.sv
// Shared types for the width-reducing unpacker, plus the async-reset flop macro
// used by its registers.
`ifndef DFF_AR
`define DFF_AR(q, d, rv, clk, rstn) \
    always_ff @(posedge clk or negedge rstn) \
        if (!rstn) q <= (rv); \
        else       q <= (d);
`endif

package unpacker_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/unpackern_tokbit_mod_counter.sv
// Mod-MOD up-counter with enable, synchronous clear and terminal-count flag.
module mod_counter #(
    parameter int MOD = 3,
    parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_next;

    assign tc = (cnt == W'(MOD - 1));

    always_comb begin
        cnt_next = cnt;
        if (clr)
            cnt_next = '0;
        else if (en)
            cnt_next = tc ? '0 : cnt + W'(1);
    end

    `DFF_AR(cnt, cnt_next, '0, clk, rstn)

endmodule

// File: rtl/unpackern_tokbit.sv
// Serializes one FACTOR*OUT_WIDTH word into FACTOR beats of OUT_WIDTH bits.
// Define UNPACK_LSB_FIRST_EN to emit the least-significant slice first.
module unpackern_tokbit
    import unpacker_pkg::*;
#(
    parameter int FACTOR    = 3,
    parameter int OUT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [FACTOR*OUT_WIDTH-1:0] data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        data_out,
    output logic                        out_last
);

    localparam int IDX_W = $clog2(FACTOR);

    state_t                      state, state_next;
    logic [FACTOR*OUT_WIDTH-1:0] hold, hold_next;
    logic [IDX_W-1:0]            idx;
    logic                        idx_tc;
    logic                        in_xfer;
    logic                        beat;
    logic [OUT_WIDTH-1:0]        slice;

    assign out_valid = (state == SEND);
    // Accepting on the final beat lets the next word follow without a bubble.
    assign in_ready  = (state == IDLE) || ((state == SEND) && idx_tc && out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign beat      = out_valid && out_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_xfer) state_next = SEND;
            SEND:    if (beat && idx_tc && !in_xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign hold_next = in_xfer ? data_in : hold;

    `DFF_AR(state, state_next, IDLE, clk, rstn)
    `DFF_AR(hold, hold_next, '0, clk, rstn)

    mod_counter #(
        .MOD (FACTOR),
        .W   (IDX_W)
    ) u_idx (
        .clk  (clk),
        .rstn (rstn),
        .en   (beat),
        .clr  (in_xfer),
        .cnt  (idx),
        .tc   (idx_tc)
    );

    always_comb begin
        slice = '0;
        for (int k = 0; k < FACTOR; k++) begin
            if (idx == IDX_W'(k)) begin
`ifdef UNPACK_LSB_FIRST_EN
                slice = hold[(k+1)*OUT_WIDTH-1 -: OUT_WIDTH];
`else
                slice = hold[(FACTOR-k)*OUT_WIDTH-1 -: OUT_WIDTH];
`endif
            end
        end
    end

    assign data_out = out_valid ? slice : '0;
    assign out_last = out_valid && idx_tc;

endmodule
